// File: rtl/exc_ctrl.sv
// Exception controller for the single-cycle LEGv8 core: captures ELR/ESR, redirects
// fetch to the handler vector, queues one external IRQ and halts on a double fault.
module exc_ctrl #(
   parameter int             N      = 64,
   parameter logic [N-1:0]   VECTOR = N'(64'hD8)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ExtIRQ,
   input  logic         NotAnInstr,
   input  logic         ERet,
   input  logic [N-1:0] PC,
   output logic         Squash,
   output logic [1:0]   PCSel,
   output logic [N-1:0] ExcVector,
   output logic [N-1:0] ELR,
   output logic [3:0]   ESR,
   output logic         ExtAck,
   output logic         InHandler,
   output logic         Halt
);

   typedef enum logic [1:0] {RUN = 2'd0, HANDLER = 2'd1, HALT = 2'd2} state_t;

   localparam logic [1:0] SEL_SEQ = 2'b00;
   localparam logic [1:0] SEL_VEC = 2'b01;
   localparam logic [1:0] SEL_ELR = 2'b10;

   localparam logic [3:0] CAUSE_IRQ = 4'b0001;
   localparam logic [3:0] CAUSE_UND = 4'b0010;

   state_t state;
   logic   irq_d, pend, rise, take_irq, exc;

   assign rise      = ExtIRQ & ~irq_d;
   assign ExcVector = VECTOR;
   assign InHandler = (state != RUN);
   assign Halt      = (state == HALT);

   // Redirect and squash are combinational so entry/return costs no extra cycle.
   always_comb begin
      exc      = 1'b0;
      take_irq = 1'b0;
      Squash   = 1'b0;
      PCSel    = SEL_SEQ;
      case (state)
         RUN: begin
            exc      = pend | NotAnInstr | ERet;
            take_irq = pend;
            if (exc) begin
               Squash = 1'b1;
               PCSel  = SEL_VEC;
            end
         end
         HANDLER: begin
            if (NotAnInstr)
               Squash = 1'b1;
            else if (ERet)
               PCSel = SEL_ELR;
         end
         HALT:    Squash = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         ELR    <= '0;
         ESR    <= '0;
         ExtAck <= 1'b0;
         pend   <= 1'b0;
         irq_d  <= 1'b0;
      end else begin
         irq_d  <= ExtIRQ;
         // A new edge arriving with the take keeps the request queued.
         pend   <= rise | (pend & ~take_irq);
         ExtAck <= take_irq;
         case (state)
            RUN: begin
               if (exc) begin
                  ELR   <= PC;
                  ESR   <= pend ? CAUSE_IRQ : CAUSE_UND;
                  state <= HANDLER;
               end
            end
            HANDLER: begin
               if (NotAnInstr)
                  state <= HALT;
               else if (ERet) begin
                  ESR   <= '0;
                  state <= RUN;
               end
            end
            HALT:    state <= HALT;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a per-cycle vector table followed by short
// hand-written sequences around reset, ack and level-held interrupts.
module tb_exc_ctrl;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset, ExtIRQ, NotAnInstr, ERet;
   logic [N-1:0] PC;
   logic         Squash, ExtAck, InHandler, Halt;
   logic [1:0]   PCSel;
   logic [N-1:0] ExcVector, ELR;
   logic [3:0]   ESR;

   int n_run = 0;
   int n_fail = 0;

   exc_ctrl #(.N(N), .VECTOR(64'hD8)) dut (
      .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .NotAnInstr(NotAnInstr), .ERet(ERet),
      .PC(PC), .Squash(Squash), .PCSel(PCSel), .ExcVector(ExcVector), .ELR(ELR),
      .ESR(ESR), .ExtAck(ExtAck), .InHandler(InHandler), .Halt(Halt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        r, irq, nai, eret;
      logic [63:0] pc;
      logic        sq;
      logic [1:0]  ps;
      logic [63:0] elr;
      logic [3:0]  esr;
      logic        ack, inh, hlt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string nm, input logic r, irq, nai, eret, input logic [63:0] pc,
                      input logic sq, input logic [1:0] ps, input logic [63:0] elr,
                      input logic [3:0] esr, input logic ack, inh, hlt);
      vec_t v;
      v.nm = nm; v.r = r; v.irq = irq; v.nai = nai; v.eret = eret; v.pc = pc;
      v.sq = sq; v.ps = ps; v.elr = elr; v.esr = esr; v.ack = ack; v.inh = inh; v.hlt = hlt;
      tbl.push_back(v);
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, before the next rise.
   task automatic drive(input logic r, irq, nai, eret, input logic [63:0] pc);
      @(negedge clk);
      reset = r; ExtIRQ = irq; NotAnInstr = nai; ERet = eret; PC = pc;
      #1;
   endtask

   task automatic expect_out(input string nm, input logic sq, input logic [1:0] ps,
                             input logic [63:0] elr, input logic [3:0] esr,
                             input logic ack, inh, hlt);
      logic [73:0] got, exp;
      got = {Squash, PCSel, ELR, ESR, ExtAck, InHandler, Halt};
      exp = {sq, ps, elr, esr, ack, inh, hlt};
      n_run++;
      if (got !== exp || ExcVector !== 64'hD8) begin
         n_fail++;
         $display("FAIL %s: got sq=%b ps=%b elr=%h esr=%b ack=%b inh=%b halt=%b vec=%h, want sq=%b ps=%b elr=%h esr=%b ack=%b inh=%b halt=%b vec=d8",
                  nm, Squash, PCSel, ELR, ESR, ExtAck, InHandler, Halt, ExcVector,
                  sq, ps, elr, esr, ack, inh, hlt);
      end
   endtask

   initial begin
      reset = 1'b1; ExtIRQ = 1'b0; NotAnInstr = 1'b0; ERet = 1'b0; PC = '0;
      repeat (2) @(posedge clk);

      //   name           r irq nai ert pc      sq ps     elr    esr      ack inh hlt
      add("rst_state",    1, 0, 0, 0, 64'h00,  0, 2'b00, 64'h00, 4'b0000, 0, 0, 0);
      add("nai_entry",    0, 0, 1, 0, 64'h20,  1, 2'b01, 64'h00, 4'b0000, 0, 0, 0);
      add("nai_handler",  0, 0, 0, 0, 64'hD8,  0, 2'b00, 64'h20, 4'b0010, 0, 1, 0);
      add("eret_ret",     0, 0, 0, 1, 64'hDC,  0, 2'b10, 64'h20, 4'b0010, 0, 1, 0);
      add("run_idle",     0, 0, 0, 0, 64'h24,  0, 2'b00, 64'h20, 4'b0000, 0, 0, 0);
      add("irq_rise",     0, 1, 0, 0, 64'h40,  0, 2'b00, 64'h20, 4'b0000, 0, 0, 0);
      add("irq_take",     0, 1, 0, 0, 64'h40,  1, 2'b01, 64'h20, 4'b0000, 0, 0, 0);
      add("irq_ack",      0, 1, 0, 0, 64'hD8,  0, 2'b00, 64'h40, 4'b0001, 1, 1, 0);
      add("ack_once",     0, 0, 0, 0, 64'hDC,  0, 2'b00, 64'h40, 4'b0001, 0, 1, 0);
      add("mask_rise",    0, 1, 0, 0, 64'hE0,  0, 2'b00, 64'h40, 4'b0001, 0, 1, 0);
      add("masked",       0, 1, 0, 0, 64'hE4,  0, 2'b00, 64'h40, 4'b0001, 0, 1, 0);
      add("eret_pend",    0, 1, 0, 1, 64'hE8,  0, 2'b10, 64'h40, 4'b0001, 0, 1, 0);
      add("b2b_entry",    0, 1, 0, 0, 64'h40,  1, 2'b01, 64'h40, 4'b0000, 0, 0, 0);
      add("b2b_handler",  0, 0, 0, 0, 64'hD8,  0, 2'b00, 64'h40, 4'b0001, 1, 1, 0);
      add("eret2",        0, 0, 0, 1, 64'hDC,  0, 2'b10, 64'h40, 4'b0001, 0, 1, 0);
      add("irq_rise2",    0, 1, 0, 0, 64'h60,  0, 2'b00, 64'h40, 4'b0000, 0, 0, 0);
      add("irq_vs_nai",   0, 1, 1, 0, 64'h64,  1, 2'b01, 64'h40, 4'b0000, 0, 0, 0);
      add("irq_wins",     0, 0, 0, 0, 64'hD8,  0, 2'b00, 64'h64, 4'b0001, 1, 1, 0);
      add("eret3",        0, 0, 0, 1, 64'hDC,  0, 2'b10, 64'h64, 4'b0001, 0, 1, 0);
      add("refault",      0, 0, 1, 0, 64'h64,  1, 2'b01, 64'h64, 4'b0000, 0, 0, 0);
      add("refault_esr",  0, 0, 0, 0, 64'hD8,  0, 2'b00, 64'h64, 4'b0010, 0, 1, 0);
      add("dbl_fault",    0, 0, 1, 1, 64'hDC,  1, 2'b00, 64'h64, 4'b0010, 0, 1, 0);
      for (int i = 0; i < 10; i++)
         add($sformatf("halt%0d", i), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 64'h100 + 64'(i * 4),
             1, 2'b00, 64'h64, 4'b0010, 0, 1, 1);
      add("halt_reset",   1, 0, 0, 0, 64'h00,  1, 2'b00, 64'h64, 4'b0010, 0, 1, 1);
      add("post_reset",   0, 0, 0, 0, 64'h00,  0, 2'b00, 64'h00, 4'b0000, 0, 0, 0);
      add("eret_illegal", 0, 0, 0, 1, 64'h18,  1, 2'b01, 64'h00, 4'b0000, 0, 0, 0);
      add("illegal_esr",  0, 0, 0, 0, 64'hD8,  0, 2'b00, 64'h18, 4'b0010, 0, 1, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].irq, tbl[i].nai, tbl[i].eret, tbl[i].pc);
         expect_out(tbl[i].nm, tbl[i].sq, tbl[i].ps, tbl[i].elr, tbl[i].esr,
                    tbl[i].ack, tbl[i].inh, tbl[i].hlt);
      end

      // Reset asserted while still in the handler clears everything on the next cycle.
      drive(1, 0, 0, 0, 64'hDC);
      drive(0, 0, 0, 0, 64'h70);
      expect_out("rst_mid_handler", 0, 2'b00, 64'h00, 4'b0000, 0, 0, 0);

      // ExtIRQ held high across entry and return must not request again.
      drive(0, 1, 0, 0, 64'h80);
      drive(0, 1, 0, 0, 64'h80);
      expect_out("lvl_take", 1, 2'b01, 64'h00, 4'b0000, 0, 0, 0);
      drive(0, 1, 0, 1, 64'hD8);
      expect_out("lvl_eret", 0, 2'b10, 64'h80, 4'b0001, 1, 1, 0);
      drive(0, 1, 0, 0, 64'h80);
      expect_out("lvl_no_repend", 0, 2'b00, 64'h80, 4'b0000, 0, 0, 0);
      drive(0, 1, 0, 0, 64'h84);
      expect_out("lvl_still_idle", 0, 2'b00, 64'h80, 4'b0000, 0, 0, 0);

      // Reset during the ack cycle drops ExtAck and forgets the request.
      drive(0, 0, 0, 0, 64'h88);
      drive(0, 1, 0, 0, 64'h90);
      drive(0, 1, 0, 0, 64'h90);
      drive(1, 0, 0, 0, 64'hD8);
      expect_out("ack_before_rst", 0, 2'b00, 64'h90, 4'b0001, 1, 1, 0);
      drive(0, 0, 0, 0, 64'h00);
      expect_out("ack_dropped", 0, 2'b00, 64'h00, 4'b0000, 0, 0, 0);
      drive(0, 0, 0, 0, 64'h04);
      expect_out("pend_discarded", 0, 2'b00, 64'h00, 4'b0000, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
